// File: rtl/axi_ram_slave.sv
// AXI4 INCR-burst RAM slave (64-bit beats); first R beat RD_LAT+1 cycles after AR, B after last W; stalls hold all outputs.
// Define AXI_RAM_SLVERR_EN to answer bursts with address bits above MEM_AW+2 set with SLVERR.
module axi_ram_slave #(
  parameter int MEM_AW = 10,
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  s_axi_awid,
  input  logic [29:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [63:0] s_axi_wdata,
  input  logic [7:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [3:0]  s_axi_bid,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [3:0]  s_axi_arid,
  input  logic [29:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [3:0]  s_axi_rid,
  output logic [63:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic        proto_err
);
  localparam logic [1:0] W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2;

  logic [63:0] mem_q [2**MEM_AW];

  logic aw_oor, ar_oor;
`ifdef AXI_RAM_SLVERR_EN
  assign aw_oor = |s_axi_awaddr[29:MEM_AW+3];
  assign ar_oor = |s_axi_araddr[29:MEM_AW+3];
`else
  assign aw_oor = 1'b0;
  assign ar_oor = 1'b0;
`endif

  // Size and burst type are deliberately ignored; every burst is INCR of 8-byte beats.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                       s_axi_awaddr, s_axi_araddr};

  // ---------------- write engine ----------------
  logic [1:0]        wstate_q, wstate_d;
  logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic [3:0]        bid_q, bid_d, wid_q, wid_d;
  logic [MEM_AW-1:0] widx_q, widx_d;
  logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic              woor_q, woor_d, perr_q, perr_d;
  logic              w_final, w_beat;

  assign w_final = (wcnt_q == wlen_q);
  assign w_beat  = (wstate_q == W_DATA) && s_axi_wvalid && wready_q;

  always_comb begin
    wstate_d  = wstate_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    bid_d     = bid_q;
    wid_d     = wid_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wcnt_d    = wcnt_q;
    woor_d    = woor_q;
    perr_d    = perr_q;
    case (wstate_q)
      W_IDLE: begin
        awready_d = 1'b1;
        if (s_axi_awvalid && awready_q) begin
          awready_d = 1'b0;
          wready_d  = 1'b1;
          wid_d     = s_axi_awid;
          widx_d    = s_axi_awaddr[MEM_AW+2:3];
          wlen_d    = s_axi_awlen;
          wcnt_d    = 8'd0;
          woor_d    = aw_oor;
          wstate_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (w_beat) begin
          widx_d = widx_q + 1'b1;
          wcnt_d = wcnt_q + 8'd1;
          // The beat counter ends the burst; a misplaced wlast is only flagged.
          if (s_axi_wlast != w_final) perr_d = 1'b1;
          if (w_final) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = woor_q ? 2'b10 : 2'b00;
            bid_d    = wid_q;
            wstate_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_beat && !woor_q) begin
      for (int b = 0; b < 8; b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  logic [1:0]        rstate_q, rstate_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [3:0]        rid_q, rid_d;
  logic [MEM_AW-1:0] ridx_q, ridx_d, ar_idx, ridx_nxt;
  logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic              roor_q, roor_d;
  logic [2:0]        lat_q, lat_d;

  assign ar_idx   = s_axi_araddr[MEM_AW+2:3];
  assign ridx_nxt = ridx_q + 1'b1;

  always_comb begin
    rstate_d  = rstate_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rid_d     = rid_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rcnt_d    = rcnt_q;
    roor_d    = roor_q;
    lat_d     = lat_q;
    case (rstate_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (s_axi_arvalid && arready_q) begin
          arready_d = 1'b0;
          rid_d     = s_axi_arid;
          ridx_d    = ar_idx;
          rlen_d    = s_axi_arlen;
          rcnt_d    = 8'd0;
          roor_d    = ar_oor;
          lat_d     = 3'd0;
          if (RD_LAT == 0) begin
            rvalid_d = 1'b1;
            rlast_d  = (s_axi_arlen == 8'd0);
            rresp_d  = ar_oor ? 2'b10 : 2'b00;
            rdata_d  = ar_oor ? 64'd0 : mem_q[ar_idx];
            rstate_d = R_DATA;
          end else begin
            rstate_d = R_WAIT;
          end
        end
      end
      R_WAIT: begin
        if (lat_q + 3'd1 == 3'(RD_LAT)) begin
          rvalid_d = 1'b1;
          rlast_d  = (rlen_q == 8'd0);
          rresp_d  = roor_q ? 2'b10 : 2'b00;
          rdata_d  = roor_q ? 64'd0 : mem_q[ridx_q];
          rstate_d = R_DATA;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      R_DATA: begin
        // Prefetch the next word on the accepting edge so beats stream without bubbles.
        if (s_axi_rready) begin
          if (!rlast_q) begin
            ridx_d  = ridx_nxt;
            rcnt_d  = rcnt_q + 8'd1;
            rdata_d = roor_q ? 64'd0 : mem_q[ridx_nxt];
            rlast_d = (rcnt_q + 8'd1 == rlen_q);
          end else begin
            rvalid_d  = 1'b0;
            arready_d = 1'b1;
            rstate_d  = R_IDLE;
          end
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      bid_q     <= 4'd0;
      wid_q     <= 4'd0;
      widx_q    <= '0;
      wlen_q    <= 8'd0;
      wcnt_q    <= 8'd0;
      woor_q    <= 1'b0;
      perr_q    <= 1'b0;
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rdata_q   <= 64'd0;
      rresp_q   <= 2'b00;
      rid_q     <= 4'd0;
      ridx_q    <= '0;
      rlen_q    <= 8'd0;
      rcnt_q    <= 8'd0;
      roor_q    <= 1'b0;
      lat_q     <= 3'd0;
    end else begin
      wstate_q  <= wstate_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      bid_q     <= bid_d;
      wid_q     <= wid_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wcnt_q    <= wcnt_d;
      woor_q    <= woor_d;
      perr_q    <= perr_d;
      rstate_q  <= rstate_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rid_q     <= rid_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rcnt_q    <= rcnt_d;
      roor_q    <= roor_d;
      lat_q     <= lat_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign proto_err     = perr_q;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: table of write/read bursts with constant expected beat data,
// R beats checked against a queue of expectations, plus reset and mid-burst reset sequences.
module tb_axi_ram_slave;
  localparam int RD_LAT = 1;
  localparam int NV = 13;

  logic        clk, rst_n;
  logic [3:0]  awid, arid, bid, rid;
  logic [29:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready, proto_err;
  logic [63:0] wdata, rdata;

  axi_ram_slave #(.MEM_AW(10), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready), .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid),
    .s_axi_bready(bready), .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst), .s_axi_arvalid(arvalid),
    .s_axi_arready(arready), .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rlast(rlast), .s_axi_rvalid(rvalid), .s_axi_rready(rready), .proto_err(proto_err)
  );

  typedef struct {
    bit          wr;
    logic [29:0] addr;
    logic [7:0]  len;
    logic [3:0]  id;
    logic [63:0] d0;        // beat i carries d0*(i+1)
    logic [7:0]  strb;
    int          bad_last;  // extra wlast on this beat index, -1 for none
    int          bstall;    // cycles bready is held low once bvalid rises
    bit          rnd;       // random rready during the read
    logic [1:0]  exp_resp;
    bit          exp_perr;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  vec_t  tbl [NV];
  rexp_t exp_q [$];
  int    n_chk = 0;
  int    n_fail = 0;
  bit    rnd_rdy = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_write(input vec_t v);
    int n;
    @(negedge clk);
    awvalid = 1'b1; awaddr = v.addr; awlen = v.len; awid = v.id;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    chk("aw_accept", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i <= int'(v.len); i++) begin
      wvalid = 1'b1;
      wdata  = v.d0 * 64'(i + 1);
      wstrb  = v.strb;
      wlast  = (i == int'(v.len)) || (i == v.bad_last);
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      chk("w_accept", wready, 1);
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    bready = (v.bstall == 0);
    n = 0;
    while (!bvalid && n < 200) begin @(negedge clk); n++; end
    chk("b_valid", bvalid, 1);
    for (int c = 0; c < v.bstall; c++) begin
      chk("b_hold", bvalid, 1);
      chk("aw_blocked", awready, 0);
      @(negedge clk);
    end
    bready = 1'b1;
    chk("bresp", bresp, v.exp_resp);
    chk("bid", bid, v.id);
    @(negedge clk);
    bready = 1'b0;
    chk("b_single", bvalid, 0);
    chk("aw_reopen", awready, 1);
    chk("proto_err", proto_err, v.exp_perr);
  endtask

  task automatic do_read(input vec_t v);
    int n;
    rexp_t e;
    for (int i = 0; i <= int'(v.len); i++) begin
      e.data = v.d0 * 64'(i + 1);
      e.resp = v.exp_resp;
      e.last = (i == int'(v.len));
      e.id   = v.id;
      exp_q.push_back(e);
    end
    rnd_rdy = v.rnd;
    @(negedge clk);
    arvalid = 1'b1; araddr = v.addr; arlen = v.len; arid = v.id;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    chk("ar_accept", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 1;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    chk("r_latency", 64'(n), 64'(RD_LAT + 1));
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin @(negedge clk); n++; end
    chk("r_all_beats", 64'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
    chk("r_idle_rvalid", rvalid, 0);
    chk("r_idle_arready", arready, 1);
    rnd_rdy = 0;
  endtask

  // R channel monitor: owns rready, pops one expectation per accepted beat.
  initial begin
    logic        stall;
    logic [63:0] sd;
    logic        sl;
    rexp_t       e;
    rready = 1'b0;
    stall  = 1'b0;
    sd     = '0;
    sl     = 1'b0;
    forever begin
      @(negedge clk);
      if (stall) begin
        chk("r_stall_data", rdata, sd);
        chk("r_stall_last", rlast, sl);
      end
      rready = rnd_rdy ? ($urandom_range(0, 1) == 1) : 1'b1;
      stall  = rvalid && !rready;
      sd     = rdata;
      sl     = rlast;
      if (rvalid && rready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL r_extra_beat: got beat 0x%0h, expected none", rdata);
        end else begin
          e = exp_q.pop_front();
          chk("rdata", rdata, e.data);
          chk("rresp", rresp, e.resp);
          chk("rlast", rlast, e.last);
          chk("rid", rid, e.id);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t rv;
    tbl[0]  = '{1, 30'h100,  8'd3,  4'd3, 64'h1111_1111_1111_1111, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[1]  = '{0, 30'h100,  8'd3,  4'd5, 64'h1111_1111_1111_1111, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[2]  = '{1, 30'h28,   8'd0,  4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[3]  = '{1, 30'h28,   8'd0,  4'd2, 64'h0,                   8'h0F, -1, 0, 0, 2'b00, 0};
    tbl[4]  = '{0, 30'h28,   8'd0,  4'd7, 64'hFFFF_FFFF_0000_0000, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[5]  = '{1, 30'h1FF8, 8'd1,  4'd9, 64'h0123_4567_89AB_CDEF, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[6]  = '{0, 30'h1FF8, 8'd1,  4'd4, 64'h0123_4567_89AB_CDEF, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[7]  = '{0, 30'h0,    8'd0,  4'd6, 64'h0246_8ACF_1357_9BDE, 8'hFF, -1, 0, 0, 2'b00, 0};
    tbl[8]  = '{1, 30'h800,  8'd15, 4'hA, 64'h0101_0101_0101_0101, 8'hFF, -1, 5, 0, 2'b00, 0};
    tbl[9]  = '{0, 30'h800,  8'd15, 4'hB, 64'h0101_0101_0101_0101, 8'hFF, -1, 0, 1, 2'b00, 0};
`ifdef AXI_RAM_SLVERR_EN
    tbl[10] = '{0, 30'h4000, 8'd0,  4'hC, 64'h0,                   8'hFF, -1, 0, 0, 2'b10, 0};
`else
    tbl[10] = '{0, 30'h4000, 8'd0,  4'hC, 64'h0246_8ACF_1357_9BDE, 8'hFF, -1, 0, 0, 2'b00, 0};
`endif
    tbl[11] = '{1, 30'h1800, 8'd2,  4'hD, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, 1,  0, 0, 2'b00, 1};
    tbl[12] = '{0, 30'h1800, 8'd2,  4'hE, 64'h0A0A_0A0A_0A0A_0A0A, 8'hFF, -1, 0, 0, 2'b00, 0};

    rst_n = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd3; awburst = 2'b01; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd3; arburst = 2'b01; arvalid = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", {awready, wready, bvalid, bresp, bid, arready, rvalid, rlast,
                          rresp, rid, proto_err}, 0);
    chk("reset_rdata", rdata, 0);
    rst_n = 1'b1;
    #1;
    chk("awready_before_edge", awready, 0);
    @(negedge clk);
    chk("awready_after_edge", awready, 1);
    chk("arready_after_edge", arready, 1);

    for (int k = 0; k < NV; k++) begin
      if (tbl[k].wr) do_write(tbl[k]);
      else           do_read(tbl[k]);
    end

    // Reset in the middle of a 4-beat write to word 200: first two beats must survive.
    @(negedge clk);
    awvalid = 1'b1; awaddr = 30'h640; awlen = 8'd3; awid = 4'd2;
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mid_w_ready", wready, 1);
      wvalid = 1'b1; wstrb = 8'hFF; wlast = 1'b0;
      wdata = 64'h0F0F_0000_1234_5678 * 64'(i + 1);
      @(negedge clk);
    end
    wvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_outputs", {awready, wready, bvalid, arready, rvalid, proto_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_awready", awready, 1);
    chk("post_reset_wready", wready, 0);
    rv = '{0, 30'h640, 8'd1, 4'd8, 64'h0F0F_0000_1234_5678, 8'hFF, -1, 0, 0, 2'b00, 0};
    do_read(rv);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
